// File: rtl/spi_arbiter.sv
// spi_arbiter: shares one spi_master among NUM_REQ requesters.
//
// - Arbitration is round-robin.
// - Only one SPI transaction is in flight at a time.
// - The winner's mode and send word are captured when it is granted.
// - The received word and a done pulse go back to the winner.
// - Optional feature macro SPI_ARB_TIMEOUT_EN adds an abort when a transaction
//   stays in WAIT too long. The abort reports req_err=1 and req_rdata=16'hFFFF.
//
// Ports:
//   sys_clk, sys_rst   clock and synchronous active-high reset
//   req                per-requester request, held until its done pulse
//   req_mode           per-requester spi_mode, slice i = [2i+1:2i]
//   req_sdata          per-requester send word, slice i = [16i+15:16i]
//   req_grant          one-hot grant, high from grant until done
//   req_done           one-cycle completion pulse to the granted requester
//   req_err            qualifies req_done: 1 = aborted by timeout
//   req_rdata          received word, held until the next completion
//   spi_en             one-cycle start pulse to spi_master
//   spi_mode           mode to spi_master
//   spi_sdata          send word to spi_master
//   spi_rdata          receive word from spi_master
//   spi_done           completion pulse from spi_master
module spi_arbiter #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned TIMEOUT_CYC = 4096
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst,
  input  logic [NUM_REQ-1:0]      req,
  input  logic [2*NUM_REQ-1:0]    req_mode,
  input  logic [16*NUM_REQ-1:0]   req_sdata,
  output logic [NUM_REQ-1:0]      req_grant,
  output logic [NUM_REQ-1:0]      req_done,
  output logic                    req_err,
  output logic [15:0]             req_rdata,
  output logic                    spi_en,
  output logic [1:0]              spi_mode,
  output logic [15:0]             spi_sdata,
  input  logic [15:0]             spi_rdata,
  input  logic                    spi_done
);

  localparam int unsigned IdxW  = $clog2(NUM_REQ);
  // One extra bit so pointer + offset cannot overflow before the wrap.
  localparam int unsigned ScanW = IdxW + 1;

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYC < 2) begin : g_param_check
    $error("spi_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYC at least 2");
  end

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

  state_e            state_q;
  logic [IdxW-1:0]   ptr_q;
  logic [IdxW-1:0]   win_q;

  logic [IdxW-1:0]   win_idx;
  logic              win_found;
  logic [ScanW-1:0]  scan;

  logic [1:0]        mode_slice  [NUM_REQ];
  logic [15:0]       sdata_slice [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
    assign mode_slice[gi]  = req_mode[2*gi +: 2];
    assign sdata_slice[gi] = req_sdata[16*gi +: 16];
  end

  // Round-robin pick: the first set req bit at or after ptr_q, wrapping modulo NUM_REQ.
  always_comb begin
    win_idx   = '0;
    win_found = 1'b0;
    scan      = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      scan = {1'b0, ptr_q} + ScanW'(k);
      if (scan >= ScanW'(NUM_REQ)) begin
        scan = scan - ScanW'(NUM_REQ);
      end
      if (!win_found && req[scan[IdxW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = scan[IdxW-1:0];
      end
    end
  end

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYC);
  logic [TmoW-1:0] tmo_q;
`else
  assign req_err = 1'b0;
`endif

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q   <= StIdle;
      ptr_q     <= '0;
      win_q     <= '0;
      req_grant <= '0;
      req_done  <= '0;
      req_rdata <= 16'h0000;
      spi_en    <= 1'b0;
      spi_mode  <= 2'b00;
      spi_sdata <= 16'h0000;
`ifdef SPI_ARB_TIMEOUT_EN
      req_err   <= 1'b0;
      tmo_q     <= '0;
`endif
    end else begin
      spi_en   <= 1'b0;
      req_done <= '0;
      unique case (state_q)
        StIdle: begin
          if (win_found) begin
            win_q     <= win_idx;
            req_grant <= NUM_REQ'(1) << win_idx;
            spi_mode  <= mode_slice[win_idx];
            spi_sdata <= sdata_slice[win_idx];
            // The start pulse coincides with the ISSUE cycle.
            spi_en    <= 1'b1;
            state_q   <= StIssue;
          end
        end
        StIssue: begin
`ifdef SPI_ARB_TIMEOUT_EN
          tmo_q <= '0;
`endif
          state_q <= StWait;
        end
        StWait: begin
          if (spi_done) begin
            req_rdata       <= spi_rdata;
            req_done[win_q] <= 1'b1;
`ifdef SPI_ARB_TIMEOUT_EN
            req_err         <= 1'b0;
`endif
            state_q         <= StDone;
          end
`ifdef SPI_ARB_TIMEOUT_EN
          else if (tmo_q == TmoW'(TIMEOUT_CYC - 1)) begin
            req_rdata       <= 16'hFFFF;
            req_done[win_q] <= 1'b1;
            req_err         <= 1'b1;
            state_q         <= StDone;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
`endif
        end
        StDone: begin
          req_grant <= '0;
          ptr_q     <= (win_q == IdxW'(NUM_REQ - 1)) ? '0 : win_q + 1'b1;
          state_q   <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_arbiter.sv
module tb_spi_arbiter;

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int Tmo       = 16;
  localparam int SingleDly = 10;
`else
  localparam int Tmo       = 4096;
  localparam int SingleDly = 40;
`endif

  logic        sys_clk;
  logic        sys_rst;
  logic [3:0]  req;
  logic [7:0]  req_mode;
  logic [63:0] req_sdata;
  logic [3:0]  req_grant;
  logic [3:0]  req_done;
  logic        req_err;
  logic [15:0] req_rdata;
  logic        spi_en;
  logic [1:0]  spi_mode;
  logic [15:0] spi_sdata;
  logic [15:0] spi_rdata;
  logic        spi_done;

  int checks;
  int failures;
  int ptr_m;              // reference round-robin pointer
  logic [15:0] last_rd;   // reference value of the held req_rdata

  spi_arbiter #(
    .NUM_REQ     (4),
    .TIMEOUT_CYC (Tmo)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .req       (req),
    .req_mode  (req_mode),
    .req_sdata (req_sdata),
    .req_grant (req_grant),
    .req_done  (req_done),
    .req_err   (req_err),
    .req_rdata (req_rdata),
    .spi_en    (spi_en),
    .spi_mode  (spi_mode),
    .spi_sdata (spi_sdata),
    .spi_rdata (spi_rdata),
    .spi_done  (spi_done)
  );

  initial sys_clk = 1'b0;
  always #10 sys_clk = ~sys_clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Round-robin model: the first requesting index at or after p, modulo 4.
  function automatic int pick(input logic [3:0] r, input int p);
    for (int k = 0; k < 4; k++) begin
      if (r[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  // Drives one transaction from grant through completion and reports what it saw.
  // Called at a negedge in IDLE with req already set; returns at the following IDLE negedge.
  task automatic serve(input int dly, input logic [15:0] rdata, input bit drop,
                       output bit ok, output int lat, output int en_cnt,
                       output logic [3:0] g, output logic [1:0] m, output logic [15:0] s,
                       output logic [3:0] d, output logic [15:0] rd, output logic e,
                       output logic [1:0] m2, output logic [15:0] s2,
                       output logic [3:0] d_after, output logic [3:0] g_after);
    ok = 1'b1; lat = 0; en_cnt = 0; g = '0;
    m = '0; s = '0; d = '0; rd = '0; e = 1'b0; m2 = '0; s2 = '0; d_after = '0; g_after = '0;
    while (g == 4'b0 && lat < 20) begin
      @(negedge sys_clk);
      lat++;
      g = req_grant;
    end
    if (g == 4'b0) begin
      ok = 1'b0;
      return;
    end
    m = spi_mode; s = spi_sdata; en_cnt += int'(spi_en);
    // Requester inputs move after grant; the snapshot must not follow them.
    req_mode  = 8'($urandom);
    req_sdata = {$urandom, $urandom};
    if (drop) req = '0;
    for (int i = 0; i < dly; i++) begin
      @(negedge sys_clk);
      en_cnt += int'(spi_en);
    end
    spi_rdata = rdata;
    spi_done  = 1'b1;
    @(posedge sys_clk);
    #1;
    spi_done  = 1'b0;
    spi_rdata = 16'($urandom);
    @(negedge sys_clk);
    d = req_done; rd = req_rdata; e = req_err; m2 = spi_mode; s2 = spi_sdata;
    en_cnt += int'(spi_en);
    @(negedge sys_clk);
    d_after = req_done; g_after = req_grant;
    en_cnt += int'(spi_en);
  endtask

  task automatic test_reset();
    sys_rst = 1'b1; req = '0; req_mode = '0; req_sdata = '0; spi_rdata = '0; spi_done = 1'b0;
    repeat (3) @(posedge sys_clk);
    #1;
    sys_rst = 1'b0;
    @(negedge sys_clk);
    ptr_m = 0; last_rd = 16'h0000;
    checks++; if (req_grant !== 4'b0) begin failures++; $display("FAIL reset_grant got=%b exp=0000", req_grant); end
    checks++; if (req_done !== 4'b0) begin failures++; $display("FAIL reset_done got=%b exp=0000", req_done); end
    checks++; if (req_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", req_err); end
    checks++; if (req_rdata !== 16'h0) begin failures++; $display("FAIL reset_rdata got=%h exp=0000", req_rdata); end
    checks++; if (spi_en !== 1'b0) begin failures++; $display("FAIL reset_en got=%b exp=0", spi_en); end
    checks++; if (spi_mode !== 2'b0) begin failures++; $display("FAIL reset_mode got=%b exp=00", spi_mode); end
    checks++; if (spi_sdata !== 16'h0) begin failures++; $display("FAIL reset_sdata got=%h exp=0000", spi_sdata); end
  endtask

  task automatic test_single();
    bit ok; int lat, en; logic [3:0] g, d, da, ga; logic [1:0] m, m2; logic [15:0] s, rd, s2;
    logic e;
    req = 4'b0010; req_mode = 8'b0000_0100; req_sdata = 64'h0000_0000_9F00_0000;
    serve(SingleDly, 16'h00EF, 1'b0, ok, lat, en, g, m, s, d, rd, e, m2, s2, da, ga);
    req = '0;
    checks++; if (!ok) begin failures++; $display("FAIL single_grant_timeout got=none exp=0010"); end
    checks++; if (lat !== 1) begin failures++; $display("FAIL single_latency got=%0d exp=1", lat); end
    checks++; if (g !== 4'b0010) begin failures++; $display("FAIL single_grant got=%b exp=0010", g); end
    checks++; if (m !== 2'b01) begin failures++; $display("FAIL single_mode got=%b exp=01", m); end
    checks++; if (s !== 16'h9F00) begin failures++; $display("FAIL single_sdata got=%h exp=9f00", s); end
    checks++; if (en !== 1) begin failures++; $display("FAIL single_en_count got=%0d exp=1", en); end
    checks++; if (d !== 4'b0010) begin failures++; $display("FAIL single_done got=%b exp=0010", d); end
    checks++; if (rd !== 16'h00EF) begin failures++; $display("FAIL single_rdata got=%h exp=00ef", rd); end
    checks++; if (e !== 1'b0) begin failures++; $display("FAIL single_err got=%b exp=0", e); end
    checks++; if (da !== 4'b0) begin failures++; $display("FAIL single_done_width got=%b exp=0000", da); end
    checks++; if (ga !== 4'b0) begin failures++; $display("FAIL single_grant_clear got=%b exp=0000", ga); end
    ptr_m = 2; last_rd = 16'h00EF;
  endtask

  // One transaction against the model; shared by the arbitration scenarios below.
  task automatic run_model_txn(input string tag, input logic [3:0] r, input bit drop);
    bit ok; int lat, en, w; logic [3:0] g, d, da, ga; logic [1:0] m, m2, em; logic [15:0] s, rd;
    logic [15:0] s2, es, rdat; logic e;
    req  = r;
    w    = pick(r, ptr_m);
    em   = req_mode[2*w +: 2];
    es   = req_sdata[16*w +: 16];
    rdat = 16'($urandom);
    serve(int'($urandom_range(1, 8)), rdat, drop, ok, lat, en, g, m, s, d, rd, e, m2, s2, da, ga);
    checks++; if (!ok) begin failures++; $display("FAIL %s_grant_timeout got=none exp=%0d", tag, w); end
    checks++; if (g !== 4'(1 << w)) begin failures++; $display("FAIL %s_grant got=%b exp=%b", tag, g, 4'(1 << w)); end
    checks++; if (lat !== 1) begin failures++; $display("FAIL %s_latency got=%0d exp=1", tag, lat); end
    checks++; if (m !== em || m2 !== em) begin failures++; $display("FAIL %s_mode got=%b/%b exp=%b", tag, m, m2, em); end
    checks++; if (s !== es || s2 !== es) begin failures++; $display("FAIL %s_sdata got=%h/%h exp=%h", tag, s, s2, es); end
    checks++; if (en !== 1) begin failures++; $display("FAIL %s_en_count got=%0d exp=1", tag, en); end
    checks++; if (d !== 4'(1 << w)) begin failures++; $display("FAIL %s_done got=%b exp=%b", tag, d, 4'(1 << w)); end
    checks++; if (rd !== rdat) begin failures++; $display("FAIL %s_rdata got=%h exp=%h", tag, rd, rdat); end
    checks++; if (e !== 1'b0) begin failures++; $display("FAIL %s_err got=%b exp=0", tag, e); end
    checks++; if (da !== 4'b0) begin failures++; $display("FAIL %s_done_width got=%b exp=0000", tag, da); end
    ptr_m = (w + 1) % 4; last_rd = rdat;
  endtask

  task automatic test_contention();
    for (int t = 0; t < 5; t++) run_model_txn("contention", 4'b1111, 1'b0);
    req = '0;
  endtask

  task automatic test_fairness();
    run_model_txn("fair_prep", 4'b0100, 1'b0);  // requester 2 served, pointer moves to 3
    checks++; if (ptr_m !== 3) begin failures++; $display("FAIL fair_pointer got=%0d exp=3", ptr_m); end
    run_model_txn("fair_wrap", 4'b0101, 1'b0);  // must pick 0 before 2
    run_model_txn("fair_next", 4'b0101, 1'b0);
    req = '0;
  endtask

  task automatic test_stray_done();
    req = '0;
    @(negedge sys_clk);
    spi_rdata = 16'hBEEF;
    spi_done  = 1'b1;
    @(posedge sys_clk);
    #1;
    spi_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge sys_clk);
      checks++; if (req_done !== 4'b0 || req_grant !== 4'b0) begin
        failures++; $display("FAIL stray_done got=done %b grant %b exp=0000", req_done, req_grant);
      end
    end
    checks++; if (req_rdata !== last_rd) begin failures++; $display("FAIL stray_rdata_hold got=%h exp=%h", req_rdata, last_rd); end
  endtask

  task automatic test_drop();
    run_model_txn("drop", 4'b1000, 1'b1);
    checks++; if (req_grant !== 4'b0) begin failures++; $display("FAIL drop_no_regrant got=%b exp=0000", req_grant); end
  endtask

  task automatic test_reset_in_wait();
    int n;
    run_model_txn("rst_prep", 4'b0010, 1'b0);   // pointer moves to 2
    req = 4'b1000;
    n = 0;
    while (req_grant == 4'b0 && n < 20) begin @(negedge sys_clk); n++; end
    checks++; if (req_grant !== 4'b1000) begin failures++; $display("FAIL rst_pre_grant got=%b exp=1000", req_grant); end
    repeat (3) @(negedge sys_clk);
    sys_rst = 1'b1; req = '0;
    @(posedge sys_clk);
    #1;
    sys_rst = 1'b0;
    @(negedge sys_clk);
    ptr_m = 0; last_rd = 16'h0000;
    checks++; if (req_grant !== 4'b0) begin failures++; $display("FAIL rst_wait_grant got=%b exp=0000", req_grant); end
    checks++; if (spi_en !== 1'b0) begin failures++; $display("FAIL rst_wait_en got=%b exp=0", spi_en); end
    checks++; if (req_done !== 4'b0) begin failures++; $display("FAIL rst_wait_done got=%b exp=0000", req_done); end
    checks++; if (req_rdata !== 16'h0) begin failures++; $display("FAIL rst_wait_rdata got=%h exp=0000", req_rdata); end
    spi_rdata = 16'h5A5A;
    spi_done  = 1'b1;
    @(posedge sys_clk);
    #1;
    spi_done = 1'b0;
    repeat (2) begin
      @(negedge sys_clk);
      checks++; if (req_done !== 4'b0) begin failures++; $display("FAIL rst_late_done got=%b exp=0000", req_done); end
    end
    run_model_txn("rst_ptr", 4'b0110, 1'b0);    // pointer 0 picks 1; a stale pointer 2 would pick 2
    req = '0;
  endtask

  task automatic test_random();
    for (int t = 0; t < 16; t++) run_model_txn("random", 4'($urandom_range(1, 15)), 1'($urandom));
    req = '0;
  endtask

`ifdef SPI_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int n, w, w2;
    logic [3:0] r2;
    req = 4'b0011;
    w = pick(req, ptr_m);
    n = 0;
    while (req_grant == 4'b0 && n < 20) begin @(negedge sys_clk); n++; end
    checks++; if (req_grant !== 4'(1 << w)) begin failures++; $display("FAIL tmo_grant got=%b exp=%b", req_grant, 4'(1 << w)); end
    n = 0;
    while (req_done == 4'b0 && n < 40) begin @(negedge sys_clk); n++; end
    // 16 WAIT cycles follow ISSUE; the abort is visible in the cycle after the last one.
    checks++; if (n !== Tmo + 1) begin failures++; $display("FAIL tmo_latency got=%0d exp=%0d", n, Tmo + 1); end
    checks++; if (req_done !== 4'(1 << w)) begin failures++; $display("FAIL tmo_done got=%b exp=%b", req_done, 4'(1 << w)); end
    checks++; if (req_err !== 1'b1) begin failures++; $display("FAIL tmo_err got=%b exp=1", req_err); end
    checks++; if (req_rdata !== 16'hFFFF) begin failures++; $display("FAIL tmo_rdata got=%h exp=ffff", req_rdata); end
    ptr_m = (w + 1) % 4;
    r2 = 4'b0011 & ~4'(1 << w);
    req = r2;
    w2 = pick(r2, ptr_m);
    @(negedge sys_clk);
    n = 0;
    while (req_grant == 4'b0 && n < 20) begin @(negedge sys_clk); n++; end
    checks++; if (req_grant !== 4'(1 << w2)) begin failures++; $display("FAIL tmo_next_grant got=%b exp=%b", req_grant, 4'(1 << w2)); end
    req = '0;
    n = 0;
    while (req_done == 4'b0 && n < 40) begin @(negedge sys_clk); n++; end
    ptr_m = (w2 + 1) % 4;
    repeat (2) @(negedge sys_clk);
  endtask
`endif

  initial begin
    checks = 0; failures = 0;
    test_reset();
    test_single();
    test_contention();
    test_fairness();
    test_stray_done();
    test_drop();
    test_reset_in_wait();
    test_random();
`ifdef SPI_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
